// File: rtl/rip_common_pkg.sv
// Shared LSU types: decoded instruction, FSM states, access size and decode helpers.
package rip_common;

  typedef struct packed {
    logic lui;
    logic auipc;
    logic jal;
    logic jalr;
    logic branch;
    logic alu;
    logic lb;
    logic lh;
    logic lw;
    logic lbu;
    logic lhu;
    logic sb;
    logic sh;
    logic sw;
  } inst_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  typedef struct packed {
    logic      mem;
    logic      store;
    logic      uns;
    acc_size_t size;
  } mem_op_t;

  // Classify an instruction; anything not exactly one load/store bit is not a memory op.
  function automatic mem_op_t decode_mem(input inst_t i);
    mem_op_t op;
    op.mem   = $onehot(i) && (i.lb | i.lh | i.lw | i.lbu | i.lhu | i.sb | i.sh | i.sw);
    op.store = i.sb | i.sh | i.sw;
    op.uns   = i.lbu | i.lhu;
    if (i.lw | i.sw)
      op.size = SZ_WORD;
    else if (i.lh | i.lhu | i.sh)
      op.size = SZ_HALF;
    else
      op.size = SZ_BYTE;
    return op;
  endfunction

  // Natural alignment check on the two low address bits.
  function automatic logic is_misaligned(input acc_size_t s, input logic [1:0] off);
    logic mis;
    case (s)
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/rip_lsu_align.sv
// Byte-lane steering: store byte enables / replicated data, load lane extract and extend.
module rip_lsu_align
  import rip_common::*;
(
  input  acc_size_t   st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  input  acc_size_t   ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_uns,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] lane;

  // Store side: enables shifted by offset, data replicated across all lanes.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = st_wdata;
    case (st_size)
      SZ_BYTE: begin
        be        = 4'b0001 << st_off;
        wdata_rep = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        be        = 4'b0011 << st_off;
        wdata_rep = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load side: shift the addressed lane down, then sign- or zero-extend.
  always_comb begin
    lane    = ld_word >> {ld_off, 3'b000};
    ld_data = ld_word;
    case (ld_size)
      SZ_BYTE: ld_data = ld_uns ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      SZ_HALF: ld_data = ld_uns ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/rip_lsu.sv
// Load/store unit: one outstanding access, alignment and timeout faults, registered outputs.
module rip_lsu
  import rip_common::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  inst_t       inst,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        access_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t       state;
  logic [CNT_W-1:0] cnt;
  acc_size_t        op_size;
  logic             op_uns;
  logic             op_store;
  logic [1:0]       op_off;

  mem_op_t          dec_c;
  logic             misal_c;
  logic [3:0]       be_c;
  logic [31:0]      wrep_c;
  logic [31:0]      ld_c;
  logic             resp_c;
  logic             timeout_c;

  // Decode the incoming request and classify the response/timeout for this cycle.
  always_comb begin
    dec_c     = decode_mem(inst);
    misal_c   = is_misaligned(dec_c.size, addr[1:0]);
    resp_c    = ((state == REQ) && mem_gnt && mem_rvalid) || ((state == WAIT) && mem_rvalid);
    timeout_c = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  rip_lsu_align u_align (
    .st_size   (dec_c.size),
    .st_off    (addr[1:0]),
    .st_wdata  (wdata),
    .be        (be_c),
    .wdata_rep (wrep_c),
    .ld_size   (op_size),
    .ld_off    (op_off),
    .ld_uns    (op_uns),
    .ld_word   (mem_rdata),
    .ld_data   (ld_c)
  );

  // Access FSM with all interface outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      op_size      <= SZ_BYTE;
      op_uns       <= 1'b0;
      op_store     <= 1'b0;
      op_off       <= 2'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rdata        <= 32'd0;
      misaligned   <= 1'b0;
      access_fault <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_be       <= 4'd0;
      mem_wdata    <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt          <= '0;
            busy         <= 1'b1;
            rdata        <= 32'd0;
            access_fault <= 1'b0;
            misaligned   <= dec_c.mem && misal_c;
            op_size      <= dec_c.size;
            op_uns       <= dec_c.uns;
            op_store     <= dec_c.store;
            op_off       <= addr[1:0];
            if (!dec_c.mem || misal_c) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= dec_c.store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= be_c;
              mem_wdata <= wrep_c;
            end
          end
        end
        REQ, WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if ((state == REQ) && mem_gnt) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
          if (resp_c) begin
            state <= DONE;
            done  <= 1'b1;
            rdata <= op_store ? 32'd0 : ld_c;
          end else if (timeout_c) begin
            state        <= DONE;
            done         <= 1'b1;
            access_fault <= 1'b1;
            rdata        <= 32'd0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
          end else if ((state == REQ) && mem_gnt) begin
            state <= WAIT;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rip_lsu.sv
// Self-checking bench for rip_lsu: directed table, timeout/reset sequences, random vs model.
module tb_rip_lsu;
  import rip_common::*;

  localparam int TO    = 256;
  localparam int K_LB  = 0;
  localparam int K_LH  = 1;
  localparam int K_LW  = 2;
  localparam int K_LBU = 3;
  localparam int K_LHU = 4;
  localparam int K_SB  = 5;
  localparam int K_SH  = 6;
  localparam int K_SW  = 7;
  localparam int K_ALU = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  inst_t       inst;
  logic        start;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;
  logic        access_fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rip_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst         (inst),
    .start        (start),
    .addr         (addr),
    .wdata        (wdata),
    .busy         (busy),
    .done         (done),
    .rdata        (rdata),
    .misaligned   (misaligned),
    .access_fault (access_fault),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  typedef struct {
    int          k;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] mw;
    int          gd;
    int          rdd;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wrep;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic inst_t mk_inst(input int k);
    inst_t i;
    i = '0;
    case (k)
      K_LB:    i.lb  = 1'b1;
      K_LH:    i.lh  = 1'b1;
      K_LW:    i.lw  = 1'b1;
      K_LBU:   i.lbu = 1'b1;
      K_LHU:   i.lhu = 1'b1;
      K_SB:    i.sb  = 1'b1;
      K_SH:    i.sh  = 1'b1;
      K_SW:    i.sw  = 1'b1;
      default: i.alu = 1'b1;
    endcase
    return i;
  endfunction

  // Reference behaviour from access size in bytes and plain arithmetic.
  task automatic model(input int k, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] mw, output logic mis, output logic [3:0] be,
                       output logic [31:0] wrep, output logic [31:0] rd);
    int sz;
    int off;
    logic st;
    logic sg;
    logic [31:0] v;
    logic [31:0] mask;
    sz   = (k == K_LB || k == K_LBU || k == K_SB) ? 1 :
           (k == K_LH || k == K_LHU || k == K_SH) ? 2 :
           (k == K_LW || k == K_SW) ? 4 : 0;
    st   = (k == K_SB || k == K_SH || k == K_SW);
    sg   = (k == K_LB || k == K_LH);
    off  = int'(a[1:0]);
    mis  = (sz > 1) && ((off % sz) != 0);
    be   = 4'(((1 << sz) - 1) << off);
    wrep = 32'd0;
    if (sz > 0)
      for (int b = 0; b < 4; b++) wrep[8*b +: 8] = wd[8*(b % sz) +: 8];
    rd = 32'd0;
    if (sz > 0 && !st && !mis) begin
      v    = mw >> (8 * off);
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      v    = v & mask;
      if (sg && v[8*sz-1]) v = v | ~mask;
      rd = v;
    end
  endtask

  // One access: start, memory handshake after gd cycles, response rdd cycles after grant.
  task automatic run_txn(input int k, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] mw, input int gd, input int rdd,
                         input logic e_mis, input logic [3:0] e_be,
                         input logic [31:0] e_wrep, input logic [31:0] e_rd);
    logic is_mem;
    logic is_st;
    is_mem     = (k != K_ALU);
    is_st      = (k == K_SB || k == K_SH || k == K_SW);
    start      = 1'b1;
    inst       = mk_inst(k);
    addr       = a;
    wdata      = wd;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    tick();
    if (!is_mem || e_mis) begin
      start = 1'($urandom_range(0, 1));
      inst  = mk_inst($urandom_range(0, 8));
      addr  = $urandom;
      chk("fast_done", done, 1);
      chk("fast_busy", busy, 1);
      chk("fast_mis", misaligned, e_mis);
      chk("fast_afault", access_fault, 0);
      chk("fast_rdata", rdata, 0);
      chk("fast_noreq", mem_req, 0);
    end else begin
      for (int c = 0; c <= gd + rdd; c++) begin
        start      = 1'($urandom_range(0, 1));
        inst       = mk_inst($urandom_range(0, 8));
        addr       = $urandom;
        wdata      = $urandom;
        mem_gnt    = (c == gd);
        mem_rvalid = (c == gd + rdd);
        mem_rdata  = mem_rvalid ? mw : $urandom;
        if (c <= gd) begin
          chk("req_high", mem_req, 1);
          chk("req_addr", mem_addr, {a[31:2], 2'b00});
          chk("req_be", 32'(mem_be), 32'(e_be));
          chk("req_we", mem_we, is_st);
          if (is_st) chk("req_wdata", mem_wdata, e_wrep);
        end else begin
          chk("req_dropped", mem_req, 0);
        end
        chk("wait_nodone", done, 0);
        chk("wait_busy", busy, 1);
        tick();
      end
      start      = 1'b0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      chk("done", done, 1);
      chk("done_rdata", rdata, e_rd);
      chk("done_mis", misaligned, 0);
      chk("done_afault", access_fault, 0);
      chk("done_noreq", mem_req, 0);
    end
    // Stray handshake in DONE must be ignored.
    mem_gnt    = 1'($urandom_range(0, 1));
    mem_rvalid = 1'($urandom_range(0, 1));
    mem_rdata  = $urandom;
    tick();
    start      = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    chk("idle_nodone", done, 0);
    chk("idle_busy", busy, 0);
    chk("hold_rdata", rdata, e_rd);
    chk("hold_mis", misaligned, e_mis);
  endtask

  // Memory never answers (or grants but never responds) until the timeout fires.
  task automatic timeout_seq(input int k, input logic [31:0] a, input logic gnt_once);
    start      = 1'b1;
    inst       = mk_inst(k);
    addr       = a;
    wdata      = $urandom;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 0; c < TO; c++) begin
      mem_gnt = gnt_once && (c == 0);
      if (c == 0 || !gnt_once) chk("to_req_held", mem_req, 1);
      else chk("to_req_low", mem_req, 0);
      chk("to_nodone", done, 0);
      tick();
    end
    mem_gnt = 1'b0;
    chk("to_done", done, 1);
    chk("to_afault", access_fault, 1);
    chk("to_rdata", rdata, 0);
    chk("to_mis", misaligned, 0);
    chk("to_noreq", mem_req, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom;
    tick();
    chk("to_idle_busy", busy, 0);
    chk("to_late_nodone", done, 0);
    chk("to_afault_hold", access_fault, 1);
    chk("to_idle_noreq", mem_req, 0);
    tick();
    mem_rvalid = 1'b0;
    chk("to_late_nodone2", done, 0);
  endtask

  initial begin
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wrep;
    logic [31:0] rd;
    int          k;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] mw;

    rst_n      = 1'b0;
    start      = 1'b0;
    inst       = '0;
    addr       = 32'd0;
    wdata      = 32'd0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mis", misaligned, 0);
    chk("rst_afault", access_fault, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_be", 32'(mem_be), 0);
    chk("rst_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    tick();

    tbl[0]  = '{K_LW,  32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, 0, 1'b0, 4'b1111, 32'h0,         32'hDEAD_BEEF};
    tbl[1]  = '{K_LB,  32'h0000_0103, 32'h0,         32'h80FF_FFFF, 0, 0, 1'b0, 4'b1000, 32'h0,         32'hFFFF_FF80};
    tbl[2]  = '{K_LBU, 32'h0000_0103, 32'h0,         32'h80FF_FFFF, 1, 0, 1'b0, 4'b1000, 32'h0,         32'h0000_0080};
    tbl[3]  = '{K_SH,  32'h0000_0202, 32'h1234_ABCD, 32'h0,         2, 1, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
    tbl[4]  = '{K_LW,  32'h0000_0101, 32'h0,         32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,         32'h0};
    tbl[5]  = '{K_LH,  32'h0000_0102, 32'h0,         32'h8001_1234, 1, 2, 1'b0, 4'b1100, 32'h0,         32'hFFFF_8001};
    tbl[6]  = '{K_LHU, 32'h0000_0102, 32'h0,         32'h8001_1234, 0, 3, 1'b0, 4'b1100, 32'h0,         32'h0000_8001};
    tbl[7]  = '{K_SB,  32'h0000_0001, 32'h0000_00A5, 32'h0,         0, 0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    tbl[8]  = '{K_SW,  32'h0000_0004, 32'hCAFE_F00D, 32'h0,         3, 0, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0};
    tbl[9]  = '{K_LH,  32'h0000_0001, 32'h0,         32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,         32'h0};
    tbl[10] = '{K_SH,  32'h0000_0003, 32'h0,         32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,         32'h0};
    tbl[11] = '{K_ALU, 32'h0000_0100, 32'h0,         32'h0,         0, 0, 1'b0, 4'b0000, 32'h0,         32'h0};
    tbl[12] = '{K_LB,  32'h0000_0000, 32'h0,         32'h1234_567F, 0, 1, 1'b0, 4'b0001, 32'h0,         32'h0000_007F};

    foreach (tbl[i])
      run_txn(tbl[i].k, tbl[i].a, tbl[i].wd, tbl[i].mw, tbl[i].gd, tbl[i].rdd,
              tbl[i].mis, tbl[i].be, tbl[i].wrep, tbl[i].rd);

    timeout_seq(K_SW, 32'h0000_0040, 1'b0);
    timeout_seq(K_LW, 32'h0000_0080, 1'b1);

    // Reset while waiting for the load response abandons the access.
    start = 1'b1;
    inst  = mk_inst(K_LW);
    addr  = 32'h0000_0300;
    tick();
    start   = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("rw_busy", busy, 1);
    chk("rw_noreq", mem_req, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rw_idle_busy", busy, 0);
    chk("rw_nodone", done, 0);
    chk("rw_rdata", rdata, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_2222;
    tick();
    mem_rvalid = 1'b0;
    chk("rw_late_nodone", done, 0);
    chk("rw_late_busy", busy, 0);
    tick();
    chk("rw_late_nodone2", done, 0);

    for (int n = 0; n < 250; n++) begin
      k  = $urandom_range(0, 8);
      a  = $urandom;
      wd = $urandom;
      mw = $urandom;
      model(k, a, wd, mw, mis, be, wrep, rd);
      run_txn(k, a, wd, mw, $urandom_range(0, 3), $urandom_range(0, 3), mis, be, wrep, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rip_lsu.md
RIP_LSU -- requirements
Module: rip_lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: max cycles from request to response before an access fault is reported.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 inst  input  rip_common::inst_t  decoded one-hot instruction; only LB/LH/LW/LBU/LHU/SB/SH/SW are acted on.
REQ-005 start  input  1  request pulse; operands valid in the same cycle.
REQ-006 addr  input  32  effective address, the ALU result rslt.
REQ-007 wdata  input  32  store source (rs2).
REQ-008 busy  output  1  high in every state other than IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 rdata  output  32  extended load result; 0 for stores and faults.
REQ-011 misaligned  output  1  valid with done: alignment fault.
REQ-012 access_fault  output  1  valid with done: timeout fault.
REQ-013 mem_req/mem_we  output  1/1  memory request and write flag.
REQ-014 mem_addr/mem_be/mem_wdata  output  32/4/32  word address, byte enables, lane-replicated write data.
REQ-015 mem_gnt/mem_rvalid  input  1/1  request accepted; response (load data or store ack) valid.
REQ-016 mem_rdata  input  32  load word.

Function
REQ-017 States: IDLE, REQ, WAIT, DONE; 2-bit encoding.
REQ-018 In IDLE with start=1, inst, addr[1:0] and wdata are latched; start is ignored in all other states.
REQ-019 Misaligned: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0 -> DONE next cycle, misaligned=1, no mem_req.
REQ-020 start with a non-load/store inst -> DONE next cycle, all flags 0, rdata=0, no mem_req.
REQ-021 Aligned access -> REQ next cycle; mem_req=1 only in REQ, with addr/we/be/wdata held stable until mem_gnt.
REQ-022 mem_addr = {addr[31:2],2'b00}; mem_we=1 for SB/SH/SW only.
REQ-023 mem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; loads use the same be.
REQ-024 mem_wdata: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
REQ-025 REQ with mem_gnt=1: -> DONE if mem_rvalid=1 in the same cycle, else -> WAIT.
REQ-026 WAIT with mem_rvalid=1 -> DONE; mem_rvalid outside REQ/WAIT is ignored.
REQ-027 Load data: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through; registered into rdata on entry to DONE.
REQ-028 Timeout counter clears on leaving IDLE and counts REQ+WAIT cycles; on reaching TIMEOUT_CYCLES -> DONE with access_fault=1, rdata=0, mem_req deasserted.
REQ-029 DONE lasts exactly one cycle with done=1, then -> IDLE; rdata/flags hold until the next start is accepted.
REQ-030 Best-case latency: start at cycle N, mem_req at N+1, done at N+2.

Reset
REQ-031 rst_n=0 at posedge -> state IDLE; busy, done, mem_req, mem_we, misaligned, access_fault = 0; rdata, mem_addr, mem_be, mem_wdata = 0; counter = 0.
REQ-032 Reset mid-transaction abandons it; no done is produced and a late mem_rvalid is ignored.

Structure
REQ-033 State enum lsu_state_t and the access-size encoding (byte/half/word) belong in rip_common; TIMEOUT_CYCLES stays a module parameter.
REQ-034 One sub-module, rip_lsu_align: combinational be/wdata generation and load lane extraction/extension.

Verification
REQ-035 LW addr=0x100, mem_gnt and mem_rvalid at N+1, mem_rdata=0xDEADBEEF -> done at N+2, rdata=0xDEADBEEF.
REQ-036 LB addr=0x103, mem_rdata=0x80FF_FFFF -> rdata=0xFFFFFF80; LBU -> 0x00000080.
REQ-037 SH addr=0x202, wdata=0x1234ABCD -> mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_addr=0x200, mem_we=1.
REQ-038 LW addr=0x101 -> done at N+1, misaligned=1, mem_req never asserted.
REQ-039 SW, mem_gnt held 0 for TIMEOUT_CYCLES cycles -> done, access_fault=1, mem_req=0 from then on.
REQ-040 Reset asserted in WAIT -> IDLE next cycle, busy=0; mem_rvalid one cycle later produces no done.
